muldiv_unit: RTL and testbench

// Iterative RV32M multiply/divide execution unit, directly downstream of the register file.

---
 rtl/muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide execution unit. Sits directly after the
// register file: it takes rs1/rs2 data, runs one shift-add (multiply) or one
// restoring-division step per cycle, and hands result, destination index and
// write strobe back to the register file write port.
//
// Ports
//   clk     in   1     clock, rising edge
//   rst     in   1     synchronous, active-high reset
//   start   in   1     request, honoured only in IDLE or DONE
//   funct3  in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                      100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a    in   XLEN  rs1 operand
//   op_b    in   XLEN  rs2 operand
//   rd_in   in   5     destination register index
//   busy    out  1     iteration in progress (PC stall)
//   done    out  1     one-cycle pulse, result/rd_out valid
//   wr_en   out  1     done with a non-zero destination
//   result  out  XLEN  op result, held until the next completion
//   rd_out  out  5     destination index of the completed op
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Latched operation context; untouched while BUSY.
  logic [2:0]        funct3_r;
  logic [XLEN-1:0]   a_mag_r;
  logic [XLEN-1:0]   b_mag_r;
  logic              neg_r;       // negate product / quotient at the end
  logic              rem_neg_r;   // remainder follows the sign of op_a
  logic [4:0]        rd_r;
  logic [CW-1:0]     count_r;
  // Multiply: {partial high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend/quotient shifting}.
  logic [2*XLEN-1:0] acc_r;

  logic [XLEN-1:0]   result_r;
  logic [4:0]        rd_out_r;
  logic              busy_r;
  logic              done_r;
  logic              wr_en_r;

  logic              accept_s;
  logic              is_div_s;
  logic              a_sgn_s;
  logic              b_sgn_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              special_s;
  logic [XLEN-1:0]   special_res_s;

  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_nxt_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] div_nxt_s;
  logic [2*XLEN-1:0] step_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_res_s;

  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic              wr_en_nxt_s;
  logic [4:0]        rd_nxt_s;

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign is_div_s = funct3[2];

  // Operand signedness for the requested op.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        a_sgn_s = op_a[XLEN-1];
        b_sgn_s = op_b[XLEN-1];
      end
      F3_MULHSU: begin
        a_sgn_s = op_a[XLEN-1];
        b_sgn_s = 1'b0;
      end
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
  end

  // Magnitudes; the most negative value maps to 2^(XLEN-1) as unsigned.
  assign a_mag_s = a_sgn_s ? ((~op_a) + ONE_X) : op_a;
  assign b_mag_s = b_sgn_s ? ((~op_b) + ONE_X) : op_b;

  // Single-cycle cases: divide by zero and signed overflow.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = ZERO_X;
    if (is_div_s) begin
      if (op_b == ZERO_X) begin
        special_s     = 1'b1;
        special_res_s = funct3[1] ? op_a : ONES_X;
      end else if (!funct3[0] && (op_a == MIN_NEG) && (op_b == ONES_X)) begin
        special_s     = 1'b1;
        special_res_s = funct3[1] ? ZERO_X : op_a;
      end else begin
        special_s     = 1'b0;
        special_res_s = ZERO_X;
      end
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO_X;
    end
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the whole accumulator right (carry enters at the top).
  assign mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                     (acc_r[0] ? {1'b0, a_mag_r} : {1'b0, ZERO_X});
  assign mul_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};

  // One restoring-division step: bring in the next dividend bit, try the
  // subtraction and keep it only if it did not go negative.
  assign div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
  assign div_diff_s  = div_shift_s - {1'b0, b_mag_r};
  assign div_nxt_s   = div_diff_s[XLEN] ?
                       {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0} :
                       {div_diff_s[XLEN-1:0],  acc_r[XLEN-2:0], 1'b1};

  assign step_nxt_s = funct3_r[2] ? div_nxt_s : mul_nxt_s;

  // Sign correction applied to the state produced by the final iteration.
  assign prod_s = neg_r ? ((~step_nxt_s) + {ZERO_X, ONE_X}) : step_nxt_s;
  assign quo_s  = step_nxt_s[XLEN-1:0];
  assign rem_s  = step_nxt_s[2*XLEN-1:XLEN];

  // Result selection at completion of an iterative op.
  always_comb begin
    final_res_s = ZERO_X;
    case (funct3_r)
      F3_MUL:                        final_res_s = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  final_res_s = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               final_res_s = neg_r ? ((~quo_s) + ONE_X) : quo_s;
      F3_REM, F3_REMU:               final_res_s = rem_neg_r ? ((~rem_s) + ONE_X) : rem_s;
      default:                       final_res_s = ZERO_X;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (special_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (count_r == LAST_CNT) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic, evaluated for the next state so the ports are registered.
  always_comb begin
    busy_nxt_s = (state_nxt_s == ST_BUSY);
    done_nxt_s = (state_nxt_s == ST_DONE);
    if (state_r == ST_BUSY) begin
      rd_nxt_s = rd_r;
    end else begin
      rd_nxt_s = rd_in;
    end
    wr_en_nxt_s = done_nxt_s && (rd_nxt_s != 5'd0);
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wr_en_r <= 1'b0;
    end else begin
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      wr_en_r <= wr_en_nxt_s;
    end
  end

  // Operand latch, iteration datapath and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_r  <= 3'b000;
      a_mag_r   <= ZERO_X;
      b_mag_r   <= ZERO_X;
      neg_r     <= 1'b0;
      rem_neg_r <= 1'b0;
      rd_r      <= 5'd0;
      count_r   <= {CW{1'b0}};
      acc_r     <= {ZERO_X, ZERO_X};
      result_r  <= ZERO_X;
      rd_out_r  <= 5'd0;
    end else if (accept_s) begin
      funct3_r  <= funct3;
      a_mag_r   <= a_mag_s;
      b_mag_r   <= b_mag_s;
      neg_r     <= a_sgn_s ^ b_sgn_s;
      rem_neg_r <= a_sgn_s;
      rd_r      <= rd_in;
      count_r   <= {CW{1'b0}};
      acc_r     <= is_div_s ? {ZERO_X, a_mag_s} : {ZERO_X, b_mag_s};
      if (special_s) begin
        result_r <= special_res_s;
        rd_out_r <= rd_in;
      end
    end else if (state_r == ST_BUSY) begin
      acc_r   <= step_nxt_s;
      count_r <= count_r + CNT_ONE;
      if (count_r == LAST_CNT) begin
        result_r <= final_res_s;
        rd_out_r <= rd_r;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign wr_en  = wr_en_r;
  assign result = result_r;
  assign rd_out = rd_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed plus randomised bench for muldiv_unit. Expected results are pushed
// to a scoreboard queue when an op is issued and popped when done is seen.
// Latency is counted in cycles after the edge that sampled start.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .wr_en  (wr_en),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model built on 64-bit products and native signed division.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    ea = (f == F_MULH || f == F_MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (f == F_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    case (f)
      F_MUL:                      return p[31:0];
      F_MULH, F_MULHSU, F_MULHU:  return p[63:32];
      F_DIV:  return (b == 32'h0) ? ONES : ((a == MIN_NEG && b == ONES) ? a : 32'(sa / sb));
      F_DIVU: return (b == 32'h0) ? ONES : a / b;
      F_REM:  return (b == 32'h0) ? a : ((a == MIN_NEG && b == ONES) ? 32'h0 : 32'(sa % sb));
      F_REMU: return (b == 32'h0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0 || (!f[0] && a == MIN_NEG && b == ONES))) return 1;
    return 33;
  endfunction

  // Drive start for one cycle; returns at the negedge of cycle k+1.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                       input bit push);
    exp_t e;
    if (push) begin
      e.res = exp_res;
      e.rd  = rd;
      e.lat = exp_lat;
      sb_q.push_back(e);
    end
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for done, then compare against the scoreboard head.
  task automatic wait_done(input string tag, input int first_lat);
    int   lat;
    int   busy_cnt;
    exp_t e;
    lat      = first_lat;
    busy_cnt = first_lat - 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".done_seen"}, 64'(done), 64'(1));
    check({tag, ".sb_nonempty"}, 64'(sb_q.size() != 0), 64'(1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".latency"}, 64'(lat), 64'(e.lat));
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(e.lat - 1));
      check({tag, ".result"}, 64'(result), 64'(e.res));
      check({tag, ".rd_out"}, 64'(rd_out), 64'(e.rd));
      check({tag, ".wr_en"}, 64'(wr_en), 64'(e.rd != 5'd0));
    end
  endtask

  task automatic idle_cycle(input string tag);
    start = 1'b0;
    @(negedge clk);
    check({tag, ".done_drop"}, 64'(done), 64'(0));
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    issue(f, a, b, rd, exp_res, exp_lat, 1'b1);
    wait_done(tag, 1);
    idle_cycle(tag);
  endtask

  initial begin
    int done_cnt;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rrd;

    // Reset asserted together with start: reset must win.
    rst    = 1'b1;
    start  = 1'b1;
    funct3 = F_MUL;
    op_a   = 32'd7;
    op_b   = 32'd3;
    rd_in  = 5'd4;
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.wr_en", 64'(wr_en), 64'(0));
    check("rst.result", 64'(result), 64'(0));
    check("rst.rd_out", 64'(rd_out), 64'(0));
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle.busy", 64'(busy), 64'(0));
    check("idle.done", 64'(done), 64'(0));

    // Multiply family.
    run_op("mul_7xm3", F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
    run_op("mulh",     F_MULH,   MIN_NEG,       ONES,          5'd6, 32'h0000_0000, 33);
    run_op("mulhsu",   F_MULHSU, MIN_NEG,       ONES,          5'd7, 32'h8000_0000, 33);
    run_op("mulhu",    F_MULHU,  MIN_NEG,       ONES,          5'd8, 32'h7FFF_FFFF, 33);

    // Divide family.
    run_op("div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   F_REM,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7", F_DIVU, 32'd100,       32'd7, 5'd11, 32'd14,        33);
    run_op("remu_100_7", F_REMU, 32'd100,       32'd7, 5'd12, 32'd2,         33);

    // Single-cycle special cases.
    run_op("div_by0",  F_DIV,  32'h0000_0055, 32'h0, 5'd13, ONES,          1);
    run_op("remu_by0", F_REMU, 32'h0000_1234, 32'h0, 5'd14, 32'h0000_1234, 1);
    run_op("div_ovf",  F_DIV,  MIN_NEG,       ONES,  5'd15, MIN_NEG,       1);
    run_op("rem_ovf",  F_REM,  MIN_NEG,       ONES,  5'd16, 32'h0,         1);

    // rd=0: done pulse without a write.
    run_op("mul_rd0", F_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 33);

    // start while BUSY is ignored.
    issue(F_MUL, 32'h10, 32'h20, 5'd17, 32'h200, 33, 1'b1);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    funct3 = F_DIVU;
    op_a   = 32'd100;
    op_b   = 32'd7;
    rd_in  = 5'd18;
    @(negedge clk);
    start  = 1'b0;
    wait_done("busy_start", 6);

    // Back-to-back: new start in the done cycle, normal and special.
    issue(F_DIVU, 32'd1000, 32'd3, 5'd19, 32'd333, 33, 1'b1);
    wait_done("b2b_norm", 1);
    issue(F_DIVU, 32'd5, 32'd0, 5'd20, ONES, 1, 1'b1);
    wait_done("b2b_spec", 1);
    idle_cycle("b2b");

    // Randomised ops against the reference model.
    for (int i = 0; i < 16; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 5 == 0) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
      rrd = 5'($urandom_range(0, 31));
      run_op("rand", rf, ra, rb, rrd, ref_res(rf, ra, rb), ref_lat(rf, ra, rb));
    end

    // Reset at count=10 of a DIVU aborts it.
    issue(F_DIVU, 32'd1000, 32'd3, 5'd21, 32'd0, 33, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.done", 64'(done), 64'(0));
    check("abort.wr_en", 64'(wr_en), 64'(0));
    check("abort.result", 64'(result), 64'(0));
    check("abort.rd_out", 64'(rd_out), 64'(0));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("abort.no_done", 64'(done_cnt), 64'(0));

    // Unit is usable again after the abort.
    run_op("post_abort", F_MUL, 32'd6, 32'd7, 5'd22, 32'd42, 33);

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
